// File: rtl/merlin_csr_pkg.sv
// Shared Zicsr definitions: funct3 encodings, CSR address field positions and
// the access-unit FSM encoding.
package merlin_csr_pkg;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    // CSR address fields: [11:10] == 2'b11 marks read-only, [9:8] is the
    // lowest privilege level allowed to touch the register.
    localparam int ADDR_ACC_HI = 11;
    localparam int ADDR_ACC_LO = 10;
    localparam int ADDR_PRV_HI = 9;
    localparam int ADDR_PRV_LO = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } csr_state_e;

endpackage

// File: rtl/csr_rmw_alu.sv
// Combinational read-modify-write for Zicsr: write, set-bits or clear-bits.
// Only funct3[1:0] matters; the register/immediate choice is made by the caller.
module csr_rmw_alu
    import merlin_csr_pkg::*;
#(
    parameter int C_XLEN = 32
) (
    input  logic [2:0]        funct3,
    input  logic [C_XLEN-1:0] old_val,
    input  logic [C_XLEN-1:0] src_val,
    output logic [C_XLEN-1:0] new_val
);

    always_comb begin
        new_val = old_val;
        case (funct3[1:0])
            F3_CSRRW[1:0]: new_val = src_val;
            F3_CSRRS[1:0]: new_val = old_val | src_val;
            F3_CSRRC[1:0]: new_val = old_val & ~src_val;
            default:       new_val = old_val;
        endcase
    end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr sequencer: IDLE -> READ -> WRITE -> RESP. Reads the CSR file, checks
// legality, issues at most one write strobe and returns the old value.
module csr_access_unit
    import merlin_csr_pkg::*;
#(
    parameter int C_XLEN = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_funct3_i,
    input  logic [11:0]       req_addr_i,
    input  logic [4:0]        req_rs1_i,
    input  logic [C_XLEN-1:0] req_rs1_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [C_XLEN-1:0] rsp_rd_data_o,
    output logic              rsp_illegal_o,
    output logic              csr_access_o,
    output logic [11:0]       csr_addr_o,
    output logic [C_XLEN-1:0] csr_data_o,
    input  logic [C_XLEN-1:0] csr_data_i,
    input  logic              csr_illegal_access_i,
    input  logic [1:0]        csr_hpl_i
);

    csr_state_e        state;
    logic [2:0]        funct3_q;
    logic [4:0]        rs1_q;
    logic [C_XLEN-1:0] rs1_data_q;
    logic [C_XLEN-1:0] old_q;
    logic              illegal_q;

    logic [C_XLEN-1:0] src_val;
    logic [C_XLEN-1:0] new_val;
    logic              write_en;
    logic              illegal_d;

    assign req_ready_o = (state == ST_IDLE);

    assign src_val  = funct3_q[2] ? {{(C_XLEN-5){1'b0}}, rs1_q} : rs1_data_q;
    // Set/clear with rs1/zimm == 0 is a pure read and must not trip the RO check.
    assign write_en = (funct3_q[1:0] == F3_CSRRW[1:0]) | (rs1_q != 5'd0);

    assign illegal_d = (funct3_q[1:0] == 2'b00)
                     | (csr_addr_o[ADDR_PRV_HI:ADDR_PRV_LO] > csr_hpl_i)
                     | csr_illegal_access_i
                     | (write_en & (csr_addr_o[ADDR_ACC_HI:ADDR_ACC_LO] == 2'b11));

    csr_rmw_alu #(.C_XLEN(C_XLEN)) u_rmw_alu (
        .funct3  (funct3_q),
        .old_val (csr_data_i),
        .src_val (src_val),
        .new_val (new_val)
    );

    // csr_addr_o doubles as the captured address so the read is valid in READ.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            funct3_q      <= '0;
            rs1_q         <= '0;
            rs1_data_q    <= '0;
            old_q         <= '0;
            illegal_q     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            rsp_rd_data_o <= '0;
            rsp_illegal_o <= 1'b0;
            csr_access_o  <= 1'b0;
            csr_addr_o    <= '0;
            csr_data_o    <= '0;
        end else if (clk_en_i) begin
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        funct3_q   <= req_funct3_i;
                        rs1_q      <= req_rs1_i;
                        rs1_data_q <= req_rs1_data_i;
                        csr_addr_o <= req_addr_i;
                        state      <= ST_READ;
                    end
                end
                ST_READ: begin
                    old_q        <= csr_data_i;
                    illegal_q    <= illegal_d;
                    csr_data_o   <= new_val;
                    csr_access_o <= write_en & ~illegal_d;
                    state        <= ST_WRITE;
                end
                ST_WRITE: begin
                    csr_access_o  <= 1'b0;
                    rsp_valid_o   <= 1'b1;
                    rsp_rd_data_o <= illegal_q ? '0 : old_q;
                    rsp_illegal_o <= illegal_q;
                    state         <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
